// File: rtl/vec_loader.sv
// rtl/vec_loader.sv - gathers a stream of elements into one vector and issues a register-bank write
//
// Purpose: loader that accepts a command (destination index plus length), collects
// that many elements from a valid/ready stream into a vector, and then pulses a
// one-cycle write strobe towards the register bank.
//
// Optional feature: define VEC_LOADER_TIMEOUT_EN to abort a LOAD after 255 cycles
// without an element arriving (err pulse, no write).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_sel = destination, cmd_len = element count
//   s_valid/s_ready      element handshake; s_data = element value
//   vec_out[N]           assembled vector (register-bank data input)
//   vec_len, vec_sel     latched length and destination of the vector
//   write                single-cycle register-bank write strobe
//   busy                 high whenever the loader is not idle
//   err                  single-cycle pulse on a rejected or aborted load
module vec_loader #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_sel,
  input  logic [7:0]      cmd_len,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BITS-1:0] s_data,
  output logic [BITS-1:0] vec_out [N-1:0],
  output logic [7:0]      vec_len,
  output logic [3:0]      vec_sel,
  output logic            write,
  output logic            busy,
  output logic            err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [BITS-1:0] r_vec [N-1:0];
  logic [7:0]      r_len;
  logic [3:0]      r_sel;
  logic [7:0]      r_idx;
  logic            r_err;

  logic            w_cmd_fire;
  logic            w_len_ok;
  logic            w_s_fire;
  logic            w_last;
  logic            w_timeout;

  // Commands are only looked at in IDLE; anything offered elsewhere is dropped.
  assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);
  assign w_len_ok   = (cmd_len != 8'd0) && (cmd_len <= 8'(N));
  assign w_s_fire   = s_valid && (r_state == ST_LOAD);
  assign w_last     = w_s_fire && (r_idx == (r_len - 8'd1));

`ifdef VEC_LOADER_TIMEOUT_EN
  logic [7:0] r_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= 8'd0;
    end else if ((w_cmd_fire && w_len_ok) || w_s_fire) begin
      r_idle <= 8'd0;
    end else if ((r_state == ST_LOAD) && !s_valid) begin
      r_idle <= r_idle + 8'd1;
    end
  end

  // The 255th consecutive empty LOAD cycle is the one that would bring the count to 255.
  assign w_timeout = (r_state == ST_LOAD) && !s_valid && (r_idle == 8'd254);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    write     = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_cmd_fire && w_len_ok) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (w_last) begin
          w_next = ST_COMMIT;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        write  = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_vec[i] <= '0;
      end
      r_len <= 8'd0;
      r_sel <= 4'd0;
      r_idx <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_cmd_fire && !w_len_ok) || w_timeout;
      if (w_cmd_fire && w_len_ok) begin
        // Zeroing here keeps entries beyond vec_len at zero for the whole load.
        for (int i = 0; i < N; i++) begin
          r_vec[i] <= '0;
        end
        r_len <= cmd_len;
        r_sel <= cmd_sel;
        r_idx <= 8'd0;
      end else if (w_s_fire) begin
        for (int i = 0; i < N; i++) begin
          if (r_idx == 8'(i)) begin
            r_vec[i] <= s_data;
          end
        end
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign vec_out = r_vec;
  assign vec_len = r_len;
  assign vec_sel = r_sel;
  assign err     = r_err;

endmodule

// File: tb/tb_vec_loader.sv
// tb/tb_vec_loader.sv - directed self-checking bench for vec_loader
module tb_vec_loader;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_sel;
  logic [7:0] cmd_len;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [7:0] vec_out [3:0];
  logic [7:0] vec_len;
  logic [3:0] vec_sel;
  logic       write;
  logic       busy;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_write = 0;
  int n_err   = 0;
  int last_write_cyc = -1;
  int hs;
  int wr0;
  int er0;

  vec_loader #(.BITS(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .vec_out   (vec_out),
    .vec_len   (vec_len),
    .vec_sel   (vec_sel),
    .write     (write),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      n_write <= n_write + 1;
      last_write_cyc <= cyc;
    end
    if (err === 1'b1) n_err <= n_err + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_v0"}, {24'd0, vec_out[0]}, {24'd0, e0});
    check({tag, "_v1"}, {24'd0, vec_out[1]}, {24'd0, e1});
    check({tag, "_v2"}, {24'd0, vec_out[2]}, {24'd0, e2});
    check({tag, "_v3"}, {24'd0, vec_out[3]}, {24'd0, e3});
  endtask

  task automatic send_cmd(input logic [3:0] sel, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_len   = len;
    tick();
    hs = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_sel = 4'd0; cmd_len = 8'd0;
    s_valid = 1'b0; s_data = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_len", {24'd0, vec_len}, 32'd0);
    check_vec("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Two elements back-to-back: write is seen in the third cycle after the handshake.
    wr0 = n_write;
    send_cmd(4'd0, 8'd2);
    check("t1_busy_load", {31'd0, busy}, 32'd1);
    check("t1_s_ready", {31'd0, s_ready}, 32'd1);
    check("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    send_elem(8'h0F);
    send_elem(8'h3C);
    check("t1_write", {31'd0, write}, 32'd1);
    check("t1_s_ready_commit", {31'd0, s_ready}, 32'd0);
    check("t1_sel", {28'd0, vec_sel}, 32'd0);
    check("t1_len", {24'd0, vec_len}, 32'd2);
    check_vec("t1", 8'h0F, 8'h3C, 8'h00, 8'h00);
    tick();
    check("t1_write_off", {31'd0, write}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);
    check("t1_nwrite", n_write - wr0, 32'd1);
    check("t1_latency", last_write_cyc - hs, 32'd2);
    check_vec("t1_hold", 8'h0F, 8'h3C, 8'h00, 8'h00);

    // Three elements with two idle cycles between; cmd_valid during LOAD is ignored.
    wr0 = n_write;
    er0 = n_err;
    send_cmd(4'd1, 8'd3);
    send_elem(8'hFF);
    cmd_valid = 1'b1; cmd_len = 8'd0;
    tick(); check("t2_busy_g1", {31'd0, busy}, 32'd1);
    tick(); check("t2_busy_g2", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b0;
    send_elem(8'h7E);
    tick(); check("t2_busy_g3", {31'd0, busy}, 32'd1);
    tick(); check("t2_busy_g4", {31'd0, busy}, 32'd1);
    send_elem(8'h7D);
    check("t2_write", {31'd0, write}, 32'd1);
    check("t2_busy_commit", {31'd0, busy}, 32'd1);
    check("t2_sel", {28'd0, vec_sel}, 32'd1);
    check("t2_len", {24'd0, vec_len}, 32'd3);
    check_vec("t2", 8'hFF, 8'h7E, 8'h7D, 8'h00);
    tick();
    check("t2_nwrite", n_write - wr0, 32'd1);
    check("t2_no_err", n_err - er0, 32'd0);

    // Illegal lengths 0 and 5: err pulse each, no write, vector untouched.
    wr0 = n_write;
    er0 = n_err;
    send_cmd(4'd5, 8'd0);
    check("t3_err0", {31'd0, err}, 32'd1);
    check("t3_busy0", {31'd0, busy}, 32'd0);
    tick();
    check("t3_err0_off", {31'd0, err}, 32'd0);
    send_cmd(4'd6, 8'd5);
    check("t3_err5", {31'd0, err}, 32'd1);
    check("t3_busy5", {31'd0, busy}, 32'd0);
    tick();
    check("t3_err5_off", {31'd0, err}, 32'd0);
    check("t3_nerr", n_err - er0, 32'd2);
    check("t3_nwrite", n_write - wr0, 32'd0);
    check("t3_sel", {28'd0, vec_sel}, 32'd1);
    check("t3_len", {24'd0, vec_len}, 32'd3);
    check_vec("t3", 8'hFF, 8'h7E, 8'h7D, 8'h00);

    // Reset mid-load clears everything at once and no write follows.
    wr0 = n_write;
    send_cmd(4'd2, 8'd4);
    send_elem(8'hA1);
    send_elem(8'hA2);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_len", {24'd0, vec_len}, 32'd0);
    check("t4_rst_sel", {28'd0, vec_sel}, 32'd0);
    check("t4_rst_write", {31'd0, write}, 32'd0);
    check_vec("t4_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t4_nwrite", n_write - wr0, 32'd0);
    send_cmd(4'd3, 8'd1);
    send_elem(8'h01);
    check("t4_write", {31'd0, write}, 32'd1);
    check("t4_sel", {28'd0, vec_sel}, 32'd3);
    check("t4_len", {24'd0, vec_len}, 32'd1);
    check_vec("t4", 8'h01, 8'h00, 8'h00, 8'h00);
    tick();

    wr0 = n_write;
    er0 = n_err;
    send_cmd(4'd4, 8'd2);
    send_elem(8'h55);
`ifdef VEC_LOADER_TIMEOUT_EN
    for (int i = 0; i < 254; i++) tick();
    check("t5_busy_254", {31'd0, busy}, 32'd1);
    check("t5_err_254", {31'd0, err}, 32'd0);
    tick();
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_sel", {28'd0, vec_sel}, 32'd4);
    check("t5_len", {24'd0, vec_len}, 32'd2);
    check_vec("t5", 8'h55, 8'h00, 8'h00, 8'h00);
    tick();
    check("t5_nwrite", n_write - wr0, 32'd0);
    check("t5_nerr", n_err - er0, 32'd1);
`else
    for (int i = 0; i < 300; i++) tick();
    check("t5_busy_wait", {31'd0, busy}, 32'd1);
    check("t5_no_err", n_err - er0, 32'd0);
    send_elem(8'hAA);
    check("t5_write", {31'd0, write}, 32'd1);
    check_vec("t5", 8'h55, 8'hAA, 8'h00, 8'h00);
    tick();
    check("t5_nwrite", n_write - wr0, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
